bcd_scan_driver: RTL and testbench



---
 rtl/bcd_scan_driver.sv | 99 +++++++++
 tb/tb_bcd_scan_driver.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// Four-digit multiplexed display scanner feeding a single segment7 decoder.
// Latches a packed BCD word and cycles digit code plus active-low anode enable.
module bcd_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [15:0]   shadow_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;

  logic          slot_end_s;
  logic          upper_zero_s;
  logic [3:0]    digit_s;
  logic [3:0]    an_lit_s;
  logic [3:0]    an_next_s;

  // Digit selection, anode pattern and leading-zero blanking for the current slot
  always_comb begin
    slot_end_s   = (cnt_r == CNT_LAST);
    digit_s      = 4'h0;
    an_lit_s     = 4'b1111;
    upper_zero_s = 1'b0;
    case (idx_r)
      2'd0: begin
        digit_s      = shadow_r[3:0];
        an_lit_s     = 4'b1110;
        upper_zero_s = 1'b0;
      end
      2'd1: begin
        digit_s      = shadow_r[7:4];
        an_lit_s     = 4'b1101;
        upper_zero_s = (shadow_r[15:4] == 12'h000);
      end
      2'd2: begin
        digit_s      = shadow_r[11:8];
        an_lit_s     = 4'b1011;
        upper_zero_s = (shadow_r[15:8] == 8'h00);
      end
      2'd3: begin
        digit_s      = shadow_r[15:12];
        an_lit_s     = 4'b0111;
        upper_zero_s = (shadow_r[15:12] == 4'h0);
      end
      default: begin
        digit_s      = 4'h0;
        an_lit_s     = 4'b1111;
        upper_zero_s = 1'b0;
      end
    endcase
    // A blanked slot keeps its timing and bcd value; only the anode stays off
    if (blank_lz && upper_zero_s) begin
      an_next_s = 4'b1111;
    end else begin
      an_next_s = an_lit_s;
    end
  end

  // Shadow register, prescaler, digit index and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r   <= 16'h0000;
      cnt_r      <= '0;
      idx_r      <= 2'd0;
      bcd        <= 4'h0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow_r <= value;
      end else begin
        shadow_r <= shadow_r;
      end
      if (slot_end_s) begin
        cnt_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
        idx_r <= idx_r;
      end
      bcd        <= digit_s;
      an         <= an_next_s;
      frame_done <= slot_end_s && (idx_r == 2'd3);
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver: driver pushes expected outputs from a
// cycle-count reference model, a monitor pops and compares after every edge.
module tb_bcd_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_done;

  bcd_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: shadow word and cycles elapsed since reset release
  logic [15:0] m_shadow = 16'h0000;
  int          m_tick = 0;
  logic        cur_blz = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; expected response for the coming edge is queued
  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic b);
    exp_t        e;
    int          slot;
    int          phase;
    logic [15:0] upper;
    logic [3:0]  oh;
    @(negedge clk);
    rst = r; load = l; value = v; blank_lz = b;
    if (r) begin
      e.bcd = 4'h0; e.an = 4'b1111; e.fd = 1'b0;
      m_shadow = 16'h0000;
      m_tick = 0;
    end else begin
      slot  = (m_tick / DIV) % 4;
      phase = m_tick % DIV;
      upper = m_shadow >> (4 * slot);
      e.bcd = upper[3:0];
      oh    = 4'b0001 << slot;
      e.an  = (b && slot > 0 && upper == 16'h0000) ? 4'b1111 : ~oh;
      e.fd  = (slot == 3 && phase == DIV - 1);
      if (l) m_shadow = v;
      m_tick++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, cur_blz);
  endtask

  // Advance until the model's idx/cnt (state before the next edge) match
  task automatic wait_slot(input int slot, input int phase);
    for (int i = 0; i < 64; i++) begin
      if ((m_tick / DIV) % 4 == slot && m_tick % DIV == phase) break;
      step(1'b0, 1'b0, 16'h0000, cur_blz);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input int run);
    step(1'b0, 1'b1, v, cur_blz);
    idle(run);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("bcd", bcd, mon_e.bcd);
      chk("an", an, mon_e.an);
      chk("frame_done", {3'b000, frame_done}, {3'b000, mon_e.fd});
    end
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int d = 0; d < 4; d++) begin
      w[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    end
    return w;
  endfunction

  initial begin
    // 1: reset then idle
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    idle(40);
    // 2: plain digits
    cur_blz = 1'b0;
    do_load(16'h1234, 20);
    // 3: leading-zero blanking
    cur_blz = 1'b1;
    do_load(16'h0045, 20);
    do_load(16'h0000, 20);
    do_load(16'h0305, 20);
    // 4: load coinciding with slot change
    cur_blz = 1'b0;
    wait_slot(0, DIV - 1);
    do_load(16'h9876, 8);
    // 5: reset mid-frame
    do_load(16'h5555, 2);
    wait_slot(2, 1);
    step(1'b1, 1'b0, 16'h0000, cur_blz);
    idle(20);
    // 6: hex codes pass through unchanged
    do_load(16'hFA0B, 20);
    cur_blz = 1'b1;
    idle(16);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) cur_blz = ~cur_blz;
      if ($urandom_range(0, 199) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), rand_word(), cur_blz);
      else if ($urandom_range(0, 7) == 0)
        step(1'b0, 1'b1, rand_word(), cur_blz);
      else
        step(1'b0, 1'b0, rand_word(), cur_blz);
    end
    idle(1);
    @(posedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
